// File: rtl/perf_counter_sequencer_if.sv
// Control-slave port of the performance counter, as driven by the sequencer.
// The sequencer is the only master on this port.
interface perf_counter_sequencer_if;
    logic [4:0]  pc_address;
    logic        pc_write;
    logic        pc_begintransfer;
    logic [31:0] pc_writedata;
    logic [31:0] pc_readdata;

    modport master (
        output pc_address,
        output pc_write,
        output pc_begintransfer,
        output pc_writedata,
        input  pc_readdata
    );

    modport slave (
        input  pc_address,
        input  pc_write,
        input  pc_begintransfer,
        input  pc_writedata,
        output pc_readdata
    );
endinterface

// File: rtl/perf_counter_sequencer.sv
// Arbitrates per-section start/stop and global clear requests into single-cycle
// slave writes, and runs a coherent hi/lo/hi snapshot readout of one section.
module perf_counter_sequencer #(
    parameter int NUM_SECTIONS = 8,
    parameter int MAX_RETRY    = 3
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [7:0]               start_req,
    input  logic [7:0]               stop_req,
    input  logic                     clear_req,
    input  logic                     snap_req,
    input  logic [2:0]               snap_sel,
    output logic                     snap_busy,
    output logic                     snap_valid,
    output logic [63:0]              snap_time,
    output logic [31:0]              snap_events,
    output logic                     req_overflow,
    perf_counter_sequencer_if.master pc
);

    localparam int         RW        = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [8:0] ONE9      = 9'd1;
    localparam logic [7:0] SECT_MASK = 8'((ONE9 << NUM_SECTIONS) - ONE9);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HI1  = 3'd1,
        S_LO   = 3'd2,
        S_HI2  = 3'd3,
        S_CMP  = 3'd4,
        S_EV   = 3'd5
    } snap_state_e;

    // Round-robin search: {found, index} of the first set bit at or after ptr.
    function automatic logic [3:0] rr_pick(input logic [7:0] vec, input logic [2:0] ptr);
        logic [3:0] pick;
        int         idx;
        pick = 4'd0;
        for (int k = NUM_SECTIONS - 1; k >= 0; k--) begin
            idx  = int'(ptr) + k;
            idx  = (idx >= NUM_SECTIONS) ? idx - NUM_SECTIONS : idx;
            pick = vec[3'(idx)] ? {1'b1, 3'(idx)} : pick;
        end
        return pick;
    endfunction

    function automatic logic [2:0] ptr_after(input logic [2:0] sec);
        return (int'(sec) + 1 >= NUM_SECTIONS) ? 3'd0 : sec + 3'd1;
    endfunction

    snap_state_e state_q, state_d;
    logic [2:0]    sel_q, sel_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [31:0]   hi1_q, hi1_d, lo_q, lo_d, hi2_q, hi2_d;
    logic          busy_q, busy_d, valid_q, valid_d;
    logic [63:0]   time_q, time_d;
    logic [31:0]   events_q, events_d;
    logic [7:0]    start_pend_q, start_pend_d, stop_pend_q, stop_pend_d;
    logic          clear_pend_q, clear_pend_d, ovf_q, ovf_d;
    logic [2:0]    rr_ptr_q, rr_ptr_d;
    logic [4:0]    addr_q, addr_d;
    logic          wr_q, wr_d;
    logic [31:0]   wdata_q, wdata_d;

    logic [7:0]  start_new_s, stop_new_s, start_eff_s, stop_eff_s;
    logic        clear_eff_s, ovf_evt_s, snap_acc_s, arb_block_s;
    logic [3:0]  stop_pick_s, start_pick_s;
    logic        arb_wr_s;
    logic [4:0]  arb_addr_s, fsm_addr_s;
    logic [31:0] arb_wdata_s;
    logic [2:0]  sel_in_s;

    // Merge this cycle's requests into the pending view; a stop beats a same-cycle start.
    always_comb begin
        stop_new_s  = stop_req & SECT_MASK;
        start_new_s = start_req & SECT_MASK & ~stop_new_s;
        ovf_evt_s   = |((start_req & stop_req & SECT_MASK)
                      | (stop_new_s & stop_pend_q)
                      | (start_new_s & start_pend_q));
        stop_eff_s  = stop_pend_q | stop_new_s;
        start_eff_s = (start_pend_q & ~stop_new_s) | start_new_s;
        clear_eff_s = clear_pend_q | clear_req;
        sel_in_s    = (int'(snap_sel) < NUM_SECTIONS) ? snap_sel : 3'd0;
        snap_acc_s  = snap_req & (state_q == S_IDLE);
        arb_block_s = busy_q | snap_acc_s;
    end

    // Command arbiter: clear, then stops, then starts; stops and starts share one pointer.
    always_comb begin
        stop_pick_s  = rr_pick(stop_eff_s, rr_ptr_q);
        start_pick_s = rr_pick(start_eff_s, rr_ptr_q);
        start_pend_d = start_eff_s;
        stop_pend_d  = stop_eff_s;
        clear_pend_d = clear_eff_s;
        ovf_d        = ovf_q | ovf_evt_s;
        rr_ptr_d     = rr_ptr_q;
        arb_wr_s     = 1'b0;
        arb_addr_s   = 5'd0;
        arb_wdata_s  = 32'd0;
        if (arb_block_s) begin
            arb_wr_s = 1'b0;
        end else if (clear_eff_s) begin
            start_pend_d = 8'd0;
            stop_pend_d  = 8'd0;
            clear_pend_d = 1'b0;
            ovf_d        = 1'b0;
            arb_wr_s     = 1'b1;
            arb_wdata_s  = 32'd1;
        end else if (stop_pick_s[3]) begin
            stop_pend_d = stop_eff_s & ~(8'd1 << stop_pick_s[2:0]);
            rr_ptr_d    = ptr_after(stop_pick_s[2:0]);
            arb_wr_s    = 1'b1;
            arb_addr_s  = {stop_pick_s[2:0], 2'b00};
        end else if (start_pick_s[3]) begin
            start_pend_d = start_eff_s & ~(8'd1 << start_pick_s[2:0]);
            rr_ptr_d     = ptr_after(start_pick_s[2:0]);
            arb_wr_s     = 1'b1;
            arb_addr_s   = {start_pick_s[2:0], 2'b01};
        end else begin
            arb_wr_s = 1'b0;
        end
        wr_d    = arb_wr_s;
        wdata_d = arb_wdata_s;
        addr_d  = arb_wr_s ? arb_addr_s : fsm_addr_s;
    end

    // Snapshot FSM; fsm_addr_s is the address for the state being entered, since
    // read data returns one cycle after the address is presented.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        retry_d    = retry_q;
        hi1_d      = hi1_q;
        lo_d       = lo_q;
        hi2_d      = hi2_q;
        busy_d     = busy_q;
        valid_d    = 1'b0;
        time_d     = time_q;
        events_d   = events_q;
        fsm_addr_s = 5'd0;
        case (state_q)
            S_IDLE: begin
                if (snap_acc_s) begin
                    sel_d      = sel_in_s;
                    retry_d    = '0;
                    busy_d     = 1'b1;
                    state_d    = S_HI1;
                    fsm_addr_s = {sel_in_s, 2'b01};
                end else begin
                    busy_d = 1'b0;
                end
            end
            S_HI1: begin
                state_d    = S_LO;
                fsm_addr_s = {sel_q, 2'b00};
            end
            S_LO: begin
                hi1_d      = pc.pc_readdata;
                state_d    = S_HI2;
                fsm_addr_s = {sel_q, 2'b01};
            end
            S_HI2: begin
                lo_d       = pc.pc_readdata;
                state_d    = S_CMP;
                fsm_addr_s = {sel_q, 2'b10};
            end
            S_CMP: begin
                hi2_d = pc.pc_readdata;
                if ((pc.pc_readdata != hi1_q) && (retry_q < RW'(MAX_RETRY))) begin
                    retry_d    = retry_q + RW'(1);
                    state_d    = S_HI1;
                    fsm_addr_s = {sel_q, 2'b01};
                end else begin
                    state_d = S_EV;
                end
            end
            S_EV: begin
                events_d = pc.pc_readdata;
                // A torn high word after the last retry leaves the low word meaningless.
                time_d   = (hi2_q != hi1_q) ? {hi2_q, 32'd0} : {hi2_q, lo_q};
                valid_d  = 1'b1;
                busy_d   = 1'b0;
                state_d  = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            sel_q        <= 3'd0;
            retry_q      <= '0;
            hi1_q        <= 32'd0;
            lo_q         <= 32'd0;
            hi2_q        <= 32'd0;
            busy_q       <= 1'b0;
            valid_q      <= 1'b0;
            time_q       <= 64'd0;
            events_q     <= 32'd0;
            start_pend_q <= 8'd0;
            stop_pend_q  <= 8'd0;
            clear_pend_q <= 1'b0;
            ovf_q        <= 1'b0;
            rr_ptr_q     <= 3'd0;
            addr_q       <= 5'd0;
            wr_q         <= 1'b0;
            wdata_q      <= 32'd0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            retry_q      <= retry_d;
            hi1_q        <= hi1_d;
            lo_q         <= lo_d;
            hi2_q        <= hi2_d;
            busy_q       <= busy_d;
            valid_q      <= valid_d;
            time_q       <= time_d;
            events_q     <= events_d;
            start_pend_q <= start_pend_d;
            stop_pend_q  <= stop_pend_d;
            clear_pend_q <= clear_pend_d;
            ovf_q        <= ovf_d;
            rr_ptr_q     <= rr_ptr_d;
            addr_q       <= addr_d;
            wr_q         <= wr_d;
            wdata_q      <= wdata_d;
        end
    end

    assign snap_busy           = busy_q;
    assign snap_valid          = valid_q;
    assign snap_time           = time_q;
    assign snap_events         = events_q;
    assign req_overflow        = ovf_q;
    assign pc.pc_address       = addr_q;
    assign pc.pc_write         = wr_q;
    assign pc.pc_begintransfer = wr_q;
    assign pc.pc_writedata     = wdata_q;

endmodule

// File: tb/tb_perf_counter_sequencer.sv
// Scoreboard bench for perf_counter_sequencer: expected writes, snapshot reads and
// snapshot results are queued at stimulus time and checked as the DUT produces them.
module tb_perf_counter_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  start_req, stop_req;
    logic        clear_req, snap_req;
    logic [2:0]  snap_sel;
    logic        snap_busy, snap_valid, req_overflow;
    logic [63:0] snap_time;
    logic [31:0] snap_events;

    perf_counter_sequencer_if pc();

    perf_counter_sequencer #(.NUM_SECTIONS(8), .MAX_RETRY(3)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start_req    (start_req),
        .stop_req     (stop_req),
        .clear_req    (clear_req),
        .snap_req     (snap_req),
        .snap_sel     (snap_sel),
        .snap_busy    (snap_busy),
        .snap_valid   (snap_valid),
        .snap_time    (snap_time),
        .snap_events  (snap_events),
        .req_overflow (req_overflow),
        .pc           (pc)
    );

    always #5 clk = ~clk;

    typedef struct { logic [4:0] addr; logic [31:0] data; int at; } wr_exp_t;
    typedef struct { logic [63:0] tim; logic [31:0] ev; int at; } snap_exp_t;

    wr_exp_t     wr_exp[$];
    snap_exp_t   snap_exp[$];
    logic [4:0]  rd_exp[$];
    logic [31:0] hi_vals[$];
    logic [31:0] lo_val, ev_val;
    int          vectors = 0, miscompares = 0, cyc = 0, c0;
    wr_exp_t     we;
    snap_exp_t   se;
    logic [4:0]  ra;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_wr(input logic [2:0] sec, input logic is_stop, input int at);
        wr_exp.push_back('{addr: {sec, is_stop ? 2'b00 : 2'b01}, data: 32'd0, at: at});
    endtask

    task automatic push_clear(input int at);
        wr_exp.push_back('{addr: 5'd0, data: 32'd1, at: at});
    endtask

    task automatic push_reads(input logic [2:0] sec, input int passes);
        for (int p = 0; p < passes; p++) begin
            rd_exp.push_back({sec, 2'b01});
            rd_exp.push_back({sec, 2'b00});
            rd_exp.push_back({sec, 2'b01});
            rd_exp.push_back({sec, 2'b10});
        end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((wr_exp.size() + snap_exp.size() + rd_exp.size()) != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_left", 64'(wr_exp.size() + snap_exp.size() + rd_exp.size()), 64'd0);
        wr_exp.delete();
        snap_exp.delete();
        rd_exp.delete();
        repeat (4) @(negedge clk);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Registered slave: section 5 hi word follows hi_vals, then lo and event count.
    always @(posedge clk) begin
        if (!pc.pc_write && pc.pc_address == 5'd21) begin
            pc.pc_readdata <= (hi_vals.size() > 0) ? hi_vals[0] : 32'd0;
            if (hi_vals.size() > 1) void'(hi_vals.pop_front());
        end else if (!pc.pc_write && pc.pc_address == 5'd20) begin
            pc.pc_readdata <= lo_val;
        end else if (!pc.pc_write && pc.pc_address == 5'd22) begin
            pc.pc_readdata <= ev_val;
        end else begin
            pc.pc_readdata <= 32'd0;
        end
    end

    // Output monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (reset_n) begin
            if (pc.pc_write || pc.pc_begintransfer) begin
                check("bt_eq_write", pc.pc_begintransfer, pc.pc_write);
                if (wr_exp.size() > 0) begin
                    we = wr_exp.pop_front();
                    check("wr_addr", pc.pc_address, we.addr);
                    check("wr_data", pc.pc_writedata, we.data);
                    check("wr_cycle", cyc, we.at);
                end else begin
                    check("unexpected_wr", pc.pc_write, 1'b0);
                end
            end
            if (snap_busy && !pc.pc_write && pc.pc_address != 5'd0) begin
                if (rd_exp.size() > 0) begin
                    ra = rd_exp.pop_front();
                    check("rd_addr", pc.pc_address, ra);
                end else begin
                    check("unexpected_rd", pc.pc_address, 5'd0);
                end
            end
            if (snap_valid) begin
                if (snap_exp.size() > 0) begin
                    se = snap_exp.pop_front();
                    check("snap_time", snap_time, se.tim);
                    check("snap_events", snap_events, se.ev);
                    check("snap_cycle", cyc, se.at);
                    check("busy_at_valid", snap_busy, 1'b0);
                end else begin
                    check("unexpected_snap", snap_valid, 1'b0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0; start_req = 8'd0; stop_req = 8'd0; clear_req = 1'b0;
        snap_req = 1'b0; snap_sel = 3'd0; lo_val = 32'd0; ev_val = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_write", pc.pc_write, 1'b0);
        check("rst_bt", pc.pc_begintransfer, 1'b0);
        check("rst_addr", pc.pc_address, 5'd0);
        check("rst_wdata", pc.pc_writedata, 32'd0);
        check("rst_busy", snap_busy, 1'b0);
        check("rst_valid", snap_valid, 1'b0);
        check("rst_ovf", req_overflow, 1'b0);
        check("rst_time", snap_time, 64'd0);
        check("rst_events", snap_events, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // All eight starts at once: back-to-back writes 1,5,...,29 from pointer 0.
        c0 = cyc; start_req = 8'hFF;
        for (int k = 0; k < 8; k++) push_wr(3'(k), 1'b0, c0 + 1 + k);
        @(negedge clk); start_req = 8'd0;
        drain(40);
        check("ovf_after_burst", req_overflow, 1'b0);

        // Single start, stop ten cycles later (pointer ends at 1).
        c0 = cyc; start_req = 8'h01; push_wr(3'd0, 1'b0, c0 + 1);
        @(negedge clk); start_req = 8'd0;
        repeat (9) @(negedge clk);
        c0 = cyc; stop_req = 8'h01; push_wr(3'd0, 1'b1, c0 + 1);
        @(negedge clk); stop_req = 8'd0;
        drain(20);

        // Clear with a same-cycle start: only the clear is issued.
        c0 = cyc; start_req = 8'h04; clear_req = 1'b1; push_clear(c0 + 1);
        @(negedge clk); start_req = 8'd0; clear_req = 1'b0;
        drain(20);
        check("ovf_after_clear_start", req_overflow, 1'b0);

        // Start and stop on one section together: stop wins, overflow set (pointer -> 2).
        c0 = cyc; start_req = 8'h02; stop_req = 8'h02; push_wr(3'd1, 1'b1, c0 + 1);
        @(negedge clk); start_req = 8'd0; stop_req = 8'd0;
        drain(20);
        check("ovf_start_stop", req_overflow, 1'b1);
        c0 = cyc; clear_req = 1'b1; push_clear(c0 + 1);
        @(negedge clk); clear_req = 1'b0;
        drain(20);
        check("ovf_cleared_1", req_overflow, 1'b0);

        // Snapshot of section 5 with requests accumulating while busy.
        hi_vals = '{32'h1}; lo_val = 32'h10; ev_val = 32'd7;
        c0 = cyc; snap_req = 1'b1; snap_sel = 3'd5;
        push_reads(3'd5, 1);
        snap_exp.push_back('{tim: 64'h1_0000_0010, ev: 32'd7, at: c0 + 6});
        push_wr(3'd6, 1'b1, c0 + 7);
        push_wr(3'd3, 1'b0, c0 + 8);
        @(negedge clk); snap_req = 1'b0; start_req = 8'h48;
        check("busy_after_accept", snap_busy, 1'b1);
        @(negedge clk); start_req = 8'h08; snap_req = 1'b1; snap_sel = 3'd2;
        @(negedge clk); start_req = 8'd0; snap_req = 1'b0; stop_req = 8'h40;
        @(negedge clk); stop_req = 8'd0;
        drain(40);
        check("ovf_coalesced", req_overflow, 1'b1);
        c0 = cyc; clear_req = 1'b1; push_clear(c0 + 1);
        @(negedge clk); clear_req = 1'b0;
        drain(20);
        check("ovf_cleared_2", req_overflow, 1'b0);

        // One torn high word, then a stable pass.
        hi_vals = '{32'h1, 32'h2, 32'h2}; lo_val = 32'h55; ev_val = 32'd9;
        c0 = cyc; snap_req = 1'b1; snap_sel = 3'd5;
        push_reads(3'd5, 2);
        snap_exp.push_back('{tim: {32'h2, 32'h55}, ev: 32'd9, at: c0 + 10});
        @(negedge clk); snap_req = 1'b0;
        drain(40);

        // High word never settles: three retries, then the low word is zeroed.
        hi_vals = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7, 32'h8};
        lo_val = 32'h77; ev_val = 32'd3;
        c0 = cyc; snap_req = 1'b1; snap_sel = 3'd5;
        push_reads(3'd5, 4);
        snap_exp.push_back('{tim: {32'h8, 32'h0}, ev: 32'd3, at: c0 + 18});
        @(negedge clk); snap_req = 1'b0;
        drain(60);

        // Reset in the middle of a burst (pointer is 4 here).
        c0 = cyc; start_req = 8'hFF; push_wr(3'd4, 1'b0, c0 + 1);
        @(negedge clk); start_req = 8'd0;
        #2 reset_n = 1'b0;
        #1;
        check("midrst_write", pc.pc_write, 1'b0);
        check("midrst_addr", pc.pc_address, 5'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        drain(10);
        check("midrst_ovf", req_overflow, 1'b0);

        // Pointer back at 0 after reset.
        c0 = cyc; start_req = 8'hFF;
        for (int k = 0; k < 8; k++) push_wr(3'(k), 1'b0, c0 + 1 + k);
        @(negedge clk); start_req = 8'd0;
        drain(40);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
